// File: rtl/reg_share_arbiter.sv
// Shared 8-bit register with a 4-requester round-robin write arbiter.
// Define REG_ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.
module reg_share_arbiter (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  req,
  input  logic [31:0] wdata,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic [7:0]  q,
  output logic [1:0]  owner,
  output logic        busy,
  output logic [7:0]  xfer_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0] state;
  logic [1:0] winner;
  logic [1:0] pick;
  logic [7:0] win_byte;

  assign win_byte = wdata[{winner, 3'b000} +: 8];

`ifdef REG_ARB_FIXED_PRIO_EN
  // Downward scan so the lowest set index is the last to overwrite pick.
  always_comb begin
    pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) pick = 2'(i);
    end
  end
`else
  logic [1:0] ptr;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    pick  = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // The pointer advances only when a write actually lands, so an abort retries from the same place.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ptr <= 2'd0;
    end else if (state == GRANT && req[winner]) begin
      ptr <= winner + 2'd1;
    end
  end
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      winner   <= 2'd0;
      gnt      <= 4'b0000;
      ack      <= 4'b0000;
      q        <= 8'h00;
      owner    <= 2'd0;
      busy     <= 1'b0;
      xfer_cnt <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          ack <= 4'b0000;
          if (req != 4'b0000) begin
            winner <= pick;
            gnt    <= 4'b0001 << pick;
            busy   <= 1'b1;
            state  <= GRANT;
          end else begin
            gnt  <= 4'b0000;
            busy <= 1'b0;
          end
        end
        GRANT: begin
          gnt <= 4'b0000;
          if (req[winner]) begin
            q        <= win_byte;
            owner    <= winner;
            ack      <= 4'b0001 << winner;
            xfer_cnt <= xfer_cnt + 8'd1;
            state    <= DONE;
          end else begin
            ack   <= 4'b0000;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        DONE: begin
          ack   <= 4'b0000;
          gnt   <= 4'b0000;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack   <= 4'b0000;
          gnt   <= 4'b0000;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench for reg_share_arbiter: directed plus randomized write transactions
// compared against a transaction-level model of the shared register.
module tb_reg_share_arbiter;

  logic        Clock;
  logic        Reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  xfer_cnt;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state.
  int         m_ptr;
  logic [7:0] m_q;
  int         m_owner;
  int         m_cnt;
  int         total_writes;

  reg_share_arbiter dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .req      (req),
    .wdata    (wdata),
    .gnt      (gnt),
    .ack      (ack),
    .q        (q),
    .owner    (owner),
    .busy     (busy),
    .xfer_cnt (xfer_cnt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before the end of the sequence");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [3:0] r);
    int w;
    w = 0;
`ifdef REG_ARB_FIXED_PRIO_EN
    for (int k = 3; k >= 0; k--) if (r[k]) w = k;
`else
    for (int k = 3; k >= 0; k--) if (r[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
`endif
    return w;
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    req   = 4'b0000;
    wdata = 32'h0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    m_ptr = 0; m_q = 8'h00; m_owner = 0; m_cnt = 0; total_writes = 0;
    check_output("rst_gnt",  32'(gnt), 32'h0);
    check_output("rst_ack",  32'(ack), 32'h0);
    check_output("rst_q",    32'(q), 32'h0);
    check_output("rst_owner", 32'(owner), 32'h0);
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_cnt",  32'(xfer_cnt), 32'h0);
  endtask

  task automatic idle_cycles(input int n);
    req = 4'b0000;
    repeat (n) begin
      @(negedge Clock);
      check_output("idle_gnt",  32'(gnt), 32'h0);
      check_output("idle_ack",  32'(ack), 32'h0);
      check_output("idle_busy", 32'(busy), 32'h0);
      check_output("idle_q",    32'(q), 32'(m_q));
    end
  endtask

  // One arbitration starting with the DUT idle; drop aborts in GRANT, hold keeps req/wdata steady.
  task automatic apply_stimulus(input logic [3:0] r, input logic [31:0] d, input bit drop,
                                input bit hold, output int w);
    logic [7:0]  b;
    logic [31:0] nd;
    w = model_winner(r);
    b = d[8*w +: 8];
    req = r;
    wdata = d;
    @(negedge Clock);
    check_output("grant_gnt",  32'(gnt), 32'(4'b0001 << w));
    check_output("grant_busy", 32'(busy), 32'h1);
    check_output("grant_ack",  32'(ack), 32'h0);
    if (drop) begin
      req = 4'b0000;
      wdata = $urandom;
    end else if (!hold) begin
      req = 4'($urandom) | (4'b0001 << w);
      nd = $urandom;
      nd[8*w +: 8] = b;
      wdata = nd;
    end
    @(negedge Clock);
    if (drop) begin
      check_output("abort_ack",   32'(ack), 32'h0);
      check_output("abort_gnt",   32'(gnt), 32'h0);
      check_output("abort_busy",  32'(busy), 32'h0);
      check_output("abort_q",     32'(q), 32'(m_q));
      check_output("abort_owner", 32'(owner), 32'(m_owner));
      check_output("abort_cnt",   32'(xfer_cnt), 32'(m_cnt));
    end else begin
      m_q = b;
      m_owner = w;
      m_ptr = (w + 1) % 4;
      m_cnt = (m_cnt + 1) % 256;
      total_writes++;
      check_output("write_q",     32'(q), 32'(m_q));
      check_output("write_ack",   32'(ack), 32'(4'b0001 << w));
      check_output("write_owner", 32'(owner), 32'(m_owner));
      check_output("write_cnt",   32'(xfer_cnt), 32'(m_cnt));
      check_output("write_gnt",   32'(gnt), 32'h0);
      check_output("write_busy",  32'(busy), 32'h1);
      if (!hold) req = 4'($urandom);
      @(negedge Clock);
      check_output("done_ack",  32'(ack), 32'h0);
      check_output("done_gnt",  32'(gnt), 32'h0);
      check_output("done_busy", 32'(busy), 32'h0);
    end
  endtask

  initial begin
    int w;
    int seq [5];
    logic [3:0] r;
    Reset = 1'b1;
    req   = 4'b0000;
    wdata = 32'h0;
    @(negedge Clock);

    // Reset then ten quiet cycles.
    do_reset();
    idle_cycles(10);

    // Single write from requester 2, inputs held.
    apply_stimulus(4'b0100, 32'h00A5_0000, 1'b0, 1'b1, w);
    check_output("single_owner", 32'(owner), 32'd2);
    check_output("single_cnt",   32'(xfer_cnt), 32'd1);
    check_output("single_q",     32'(q), 32'hA5);

    // All requesters held high.
    do_reset();
`ifdef REG_ARB_FIXED_PRIO_EN
    seq = '{0, 0, 0, 0, 0};
`else
    seq = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(4'b1111, 32'h4433_2211 + 32'(i), 1'b0, 1'b1, w);
      check_output("rr_order", 32'(owner), 32'(seq[i]));
    end
    idle_cycles(2);

    // Requester 1 aborts in GRANT, then a full request reuses the same pointer.
    apply_stimulus(4'b0010, 32'h0000_7700, 1'b1, 1'b0, w);
    apply_stimulus(4'b1111, $urandom, 1'b0, 1'b0, w);
    check_output("post_abort_winner", 32'(w), 32'(model_winner(4'b1111) == 0 ? 3 : model_winner(4'b1111) - 1));
    idle_cycles(1);

    // Randomized traffic with occasional aborts.
    for (int i = 0; i < 40; i++) begin
      r = 4'($urandom_range(1, 15));
      apply_stimulus(r, $urandom, ($urandom_range(0, 4) == 0), 1'b0, w);
      idle_cycles($urandom_range(0, 2));
    end

    // Reset arriving in GRANT cancels the write.
    req = 4'b1000;
    wdata = 32'h3C00_0000;
    @(negedge Clock);
    check_output("mid_rst_gnt", 32'(gnt), 32'h8);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    req = 4'b0000;
    m_ptr = 0; m_q = 8'h00; m_owner = 0; m_cnt = 0; total_writes = 0;
    check_output("mid_rst_q",    32'(q), 32'h0);
    check_output("mid_rst_ack",  32'(ack), 32'h0);
    check_output("mid_rst_busy", 32'(busy), 32'h0);
    check_output("mid_rst_cnt",  32'(xfer_cnt), 32'h0);
    idle_cycles(1);

    // Counter wrap over 257 completed writes.
    do_reset();
    while (total_writes < 256) begin
      apply_stimulus(4'($urandom_range(1, 15)), $urandom, 1'b0, 1'b0, w);
    end
    check_output("wrap_256", 32'(xfer_cnt), 32'h00);
    apply_stimulus(4'($urandom_range(1, 15)), $urandom, 1'b0, 1'b0, w);
    check_output("wrap_257", 32'(xfer_cnt), 32'h01);
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
